radix4_otf_quotient_converter: RTL

Sequential on-the-fly converter at the consumer end of the radix-4 SRT quotient-digit path. It accepts one signed-digit quotient digit q ∈ {-2..2} per handshake from the digit-selection stage. It maintains the Q/QM register pair and emits the final two's-complement quotient, corrected by the final-remainder sign. It sits between the divider recurrence datapath and the normalise/round stage.

---
 rtl/radix4_otf_quotient_converter.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/radix4_otf_quotient_converter.sv
// ============================================================================
// radix4_otf_quotient_converter
//
// On-the-fly converter for radix-4 SRT signed-digit quotients. Digits
// q in {-2..2} arrive one per handshake from the digit-selection stage. The
// converter keeps the classic Q/QM register pair (QM = Q - 1 at all times),
// so each new digit is just an append of two bits onto either Q or QM. No
// carry-propagate adder is needed on the digit path. After NDIGITS digits the
// two's-complement quotient is emitted. When the final partial remainder is
// negative, QM is emitted instead of Q (the -1 correction).
//
// Optional feature (macro RADIX4_OTF_INEXACT_EN):
//   adds input last_rem_zero_i and output inexact_o. inexact_o is registered
//   together with q_o as ~last_rem_zero_i.
//
// Parameters
//   NDIGITS : radix-4 digits per division (minimum 2)
//   QW      : quotient width, derived as 2*NDIGITS (do not override)
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   start_i         : pulse; aborts anything in flight and begins a new
//                     conversion on the next cycle
//   busy_o          : high while converting or holding a result
//   digit_valid_i   : digit_i is valid
//   digit_ready_o   : converter accepts a digit (state-derived only)
//   digit_i         : 3-bit two's-complement quotient digit
//   last_rem_neg_i  : final remainder negative, sampled with the last digit
//   q_valid_o       : quotient valid
//   q_ready_i       : downstream accepts the quotient
//   q_o             : final quotient, two's complement modulo 2^QW
//   digit_err_o     : sticky flag, an illegal digit code was seen
//   state_dbg       : current FSM state, for debug and checkers
//
// Handshake semantics (both channels): a transfer happens on a rising clock
// edge where valid and ready are both high. Once raised, q_valid_o stays high
// with q_o stable until that transfer. digit_ready_o never depends
// combinationally on digit_valid_i.
// ============================================================================
module radix4_otf_quotient_converter #(
    parameter int NDIGITS = 14,
    parameter int QW      = 2 * NDIGITS
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_i,
    output logic          busy_o,
    input  logic          digit_valid_i,
    output logic          digit_ready_o,
    input  logic [2:0]    digit_i,
    input  logic          last_rem_neg_i,
`ifdef RADIX4_OTF_INEXACT_EN
    input  logic          last_rem_zero_i,
    output logic          inexact_o,
`endif
    output logic          q_valid_o,
    input  logic          q_ready_i,
    output logic [QW-1:0] q_o,
    output logic          digit_err_o,
    output logic [1:0]    state_dbg
);

    localparam int CW = $clog2(NDIGITS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [QW-1:0]   q_reg;
    logic [QW-1:0]   qm_reg;
    logic [CW-1:0]   count_q;

    logic            digit_accept;
    logic            last_digit;
    logic            digit_illegal;
    logic [2:0]      digit_eff;
    logic [QW-1:0]   q_next;
    logic [QW-1:0]   qm_next;

    // ------------------------------------------------------------------
    // Handshake and digit decode
    // ------------------------------------------------------------------
    assign digit_ready_o = (state_q == CONV);
    assign busy_o        = (state_q != IDLE);
    assign state_dbg     = state_q;

    assign digit_accept  = digit_valid_i & digit_ready_o;
    assign last_digit    = digit_accept & (count_q == CW'(NDIGITS - 1));

    // Codes +3, -4 and -3 are outside the digit set. They are folded to
    // zero so the conversion still advances by one digit position.
    assign digit_illegal = (digit_i == 3'b011) || (digit_i == 3'b100) ||
                           (digit_i == 3'b101);
    assign digit_eff     = digit_illegal ? 3'b000 : digit_i;

    // ------------------------------------------------------------------
    // On-the-fly append. After a shift by two the low bits are zero, so
    // "4X + k" with 0 <= k <= 3 is a plain concatenation.
    //   q = +1 : Q' = 4Q +1   QM' = 4Q +0
    //   q = +2 : Q' = 4Q +2   QM' = 4Q +1
    //   q =  0 : Q' = 4Q +0   QM' = 4QM+3
    //   q = -1 : Q' = 4QM+3   QM' = 4QM+2
    //   q = -2 : Q' = 4QM+2   QM' = 4QM+1
    // ------------------------------------------------------------------
    always_comb begin
        q_next  = {q_reg[QW-3:0], 2'b00};
        qm_next = {qm_reg[QW-3:0], 2'b11};
        case (digit_eff)
            3'b001: begin
                q_next  = {q_reg[QW-3:0], 2'b01};
                qm_next = {q_reg[QW-3:0], 2'b00};
            end
            3'b010: begin
                q_next  = {q_reg[QW-3:0], 2'b10};
                qm_next = {q_reg[QW-3:0], 2'b01};
            end
            3'b111: begin
                q_next  = {qm_reg[QW-3:0], 2'b11};
                qm_next = {qm_reg[QW-3:0], 2'b10};
            end
            3'b110: begin
                q_next  = {qm_reg[QW-3:0], 2'b10};
                qm_next = {qm_reg[QW-3:0], 2'b01};
            end
            default: begin
                q_next  = {q_reg[QW-3:0], 2'b00};
                qm_next = {qm_reg[QW-3:0], 2'b11};
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: next state. start_i overrides everything else.
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = CONV;
        end else begin
            case (state_q)
                IDLE:    state_d = IDLE;
                CONV:    if (last_digit) state_d = DONE;
                DONE:    if (q_ready_i)  state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Datapath and registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_reg       <= '0;
            qm_reg      <= '1;
            count_q     <= '0;
            q_o         <= '0;
            q_valid_o   <= 1'b0;
            digit_err_o <= 1'b0;
        end else if (start_i) begin
            // q_o keeps its last value; only the working state is cleared.
            q_reg       <= '0;
            qm_reg      <= '1;
            count_q     <= '0;
            q_valid_o   <= 1'b0;
            digit_err_o <= 1'b0;
        end else if (digit_accept) begin
            q_reg   <= q_next;
            qm_reg  <= qm_next;
            count_q <= count_q + CW'(1);
            if (digit_illegal) begin
                digit_err_o <= 1'b1;
            end
            if (last_digit) begin
                // QM = Q - 1 gives the negative-remainder correction for free.
                q_o       <= last_rem_neg_i ? qm_next : q_next;
                q_valid_o <= 1'b1;
            end
        end else if ((state_q == DONE) && q_ready_i) begin
            q_valid_o <= 1'b0;
        end
    end

`ifdef RADIX4_OTF_INEXACT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            inexact_o <= 1'b0;
        end else if (start_i) begin
            inexact_o <= 1'b0;
        end else if (last_digit) begin
            inexact_o <= ~last_rem_zero_i;
        end
    end
`endif

endmodule
